reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- Receiving end of the decoder's issue interface in the Tomasulo core.
- Accepts one issued entry per cycle and hands the decoder the next free tag.
- Answers the decoder's two combinational operand-fetch queries and captures CDB results.
- Retires entries strictly in order to the register file (register writes) and the LSB (store release).

Parameters:
- TAG_W, 4, ROB tag width. Tag 0 is reserved as "no tag".
- DEPTH, 15, entry count; must equal 2^TAG_W-1. The entry at index i has tag i+1.
- OP_W, 6, internal opcode width (INSIDE_OPCODE_WIDTH).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global ready; when low, state freezes.
- in_dec_op  in  OP_W  issued opcode; `NOP = no issue this cycle.
- in_dec_dest  in  32  destination; [4:0] = rd for register ops.
- in_dec_isready  in  1  entry value already known (LUI/AUIPC).
- in_dec_value  in  32  value, used when isready=1.
- out_dec_freetag  out  TAG_W  tag the next issue receives; 0 when full.
- out_full  out  1  count==DEPTH.
- in_fetch_tag1/in_fetch_tag2  in  TAG_W  operand query tags.
- out_fetch_value1/out_fetch_value2  out  32  value of the queried entry.
- out_fetch_ready1/out_fetch_ready2  out  1  queried entry is valid and ready.
- in_cdb_tag  in  TAG_W  broadcast tag; 0 = no broadcast.
- in_cdb_value  in  32  broadcast result.
- out_commit_valid  out  1  one-cycle pulse, register write retired.
- out_commit_reg  out  5  rd of the retired entry.
- out_commit_value  out  32  value of the retired entry.
- out_commit_tag  out  TAG_W  tag of the retired entry; the register file clears busy only if this matches its robtag.
- out_store_commit_tag  out  TAG_W  one-cycle store release to the LSB; 0 otherwise.

Behaviour:
- Storage: circular buffer with head, tail and count registers. Per-entry fields: busy, ready, op, dest, value.
- Reset: head=tail=count=0; all busy/ready cleared. Commit outputs are 0 and freetag=1 in the cycle after rst.
- out_dec_freetag: tail+1 when count<DEPTH, else 0. Derived from registered state only, so a same-cycle commit does not free a slot for issue.
- Issue: when rdy && in_dec_op!=`NOP && count<DEPTH:
  - write the tail entry with busy=1, ready=in_dec_isready, op, dest, value;
  - advance tail, wrapping DEPTH-1 -> 0.
  - Issue while full is silently dropped.
- CDB: when in_cdb_tag!=0 and that entry is busy, set value=in_cdb_value and ready=1. A broadcast to a non-busy tag is ignored.
- Fetch: purely combinational. ready=1 and value=entry.value only if tag!=0 and the entry is busy and ready; otherwise ready=0 and value=0. An entry retiring this cycle still answers, because it is still busy before the clock edge.
- Commit: at most one entry per cycle, from the head, when the head entry is busy and ready. Outputs are registered (latency 1 cycle after ready is visible).
  - op in {`SB,`SH,`SW}: out_store_commit_tag=head+1; out_commit_valid=0.
  - otherwise: out_commit_valid=1 with reg=dest[4:0], value and tag. rd=0 still pulses; the register file discards it.
  - The head entry is cleared, head advances with wrap, count decrements.
- Simultaneous issue and commit: count is unchanged.
- CDB ready in cycle N allows commit at the edge ending cycle N+1, not at the edge that captures it.
- rdy=0: no state update; the commit pulse outputs drive 0.
- Reset asserted mid-operation: discards every entry on the next edge; in-flight broadcasts are lost.

Optional Feature:
- ROB_CDB_BYPASS_EN
  - Defined: a fetch port whose tag equals a live in_cdb_tag (entry busy) returns ready=1 and value=in_cdb_value in the same cycle, so the decoder never captures a tag that resolves in that cycle.
  - Undefined: fetch reflects stored state only; the RS/LSB must snoop the CDB to pick the value up.

Test Plan:
- Reset, then issue LUI (isready=1, value=0x12345000, dest=5) -> freetag 1→2; one cycle later commit pulse with reg=5, value=0x12345000, tag=1; freetag back to 2, count 0.
- Issue 15 ADDI entries with no CDB -> out_full=1 and freetag=0; a 16th issue is dropped; CDB tag1 = 7 -> next cycle ready, following cycle commit of tag1, value 7.
- Issue tags 1,2; CDB tag2=0xAA, then tag1=0x55 -> commits occur in order: tag1=0x55, then tag2=0xAA on consecutive cycles.
- Issue SW, CDB its tag -> out_store_commit_tag=tag for one cycle and out_commit_valid stays 0.
- Fetch tag3 in the same cycle the CDB broadcasts tag3=0x99 -> ready=1/value=0x99 with ROB_CDB_BYPASS_EN, ready=0 without; the next cycle both report ready.
- Fill 15, commit 3, issue 3 -> tags 1,2,3 are reused (wrap-around); assert rst mid-stream -> all ready=0, freetag=1.

Source files
------------

// File: rtl/reorder_buffer_if.sv
// Decoder/CDB/commit bundle of the reorder buffer.
// The ROB takes the slave side; the decoder, CDB and retire consumers sit on the master side.
interface reorder_buffer_if #(
  parameter int TAG_W = 4,
  parameter int OP_W  = 6
);
  logic [OP_W-1:0]  in_dec_op;
  logic [31:0]      in_dec_dest;
  logic             in_dec_isready;
  logic [31:0]      in_dec_value;
  logic [TAG_W-1:0] out_dec_freetag;
  logic             out_full;

  logic [TAG_W-1:0] in_fetch_tag1;
  logic [TAG_W-1:0] in_fetch_tag2;
  logic [31:0]      out_fetch_value1;
  logic [31:0]      out_fetch_value2;
  logic             out_fetch_ready1;
  logic             out_fetch_ready2;

  logic [TAG_W-1:0] in_cdb_tag;
  logic [31:0]      in_cdb_value;

  logic             out_commit_valid;
  logic [4:0]       out_commit_reg;
  logic [31:0]      out_commit_value;
  logic [TAG_W-1:0] out_commit_tag;
  logic [TAG_W-1:0] out_store_commit_tag;

  modport master (
    output in_dec_op, in_dec_dest, in_dec_isready, in_dec_value,
    output in_fetch_tag1, in_fetch_tag2, in_cdb_tag, in_cdb_value,
    input  out_dec_freetag, out_full,
    input  out_fetch_value1, out_fetch_value2, out_fetch_ready1, out_fetch_ready2,
    input  out_commit_valid, out_commit_reg, out_commit_value, out_commit_tag,
    input  out_store_commit_tag
  );

  modport slave (
    input  in_dec_op, in_dec_dest, in_dec_isready, in_dec_value,
    input  in_fetch_tag1, in_fetch_tag2, in_cdb_tag, in_cdb_value,
    output out_dec_freetag, out_full,
    output out_fetch_value1, out_fetch_value2, out_fetch_ready1, out_fetch_ready2,
    output out_commit_valid, out_commit_reg, out_commit_value, out_commit_tag,
    output out_store_commit_tag
  );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retiring reorder buffer for the Tomasulo core; entry index i carries tag i+1, tag 0 means "no tag".
// Define ROB_CDB_BYPASS_EN to let operand fetches see a same-cycle CDB broadcast.
module reorder_buffer #(
  parameter int TAG_W = 4,
  parameter int DEPTH = 15,
  parameter int OP_W  = 6,
  parameter logic [OP_W-1:0] OP_NOP = OP_W'(0),
  parameter logic [OP_W-1:0] OP_SB  = OP_W'(20),
  parameter logic [OP_W-1:0] OP_SH  = OP_W'(21),
  parameter logic [OP_W-1:0] OP_SW  = OP_W'(22)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rdy,
  reorder_buffer_if.slave rob
);
  typedef logic [TAG_W-1:0] tag_t;

  // Only rd is ever retired, so only dest[4:0] is kept per entry.
  logic            busy_q  [DEPTH];
  logic            ready_q [DEPTH];
  logic [OP_W-1:0] op_q    [DEPTH];
  logic [4:0]      dest_q  [DEPTH];
  logic [31:0]     value_q [DEPTH];

  tag_t        head_q, head_d, tail_q, tail_d, count_q, count_d;
  logic        commitValid_q, commitValid_d;
  logic [4:0]  commitReg_q, commitReg_d;
  logic [31:0] commitValue_q, commitValue_d;
  tag_t        commitTag_q, commitTag_d;
  tag_t        storeTag_q, storeTag_d;

  logic notFull, doIssue, doCommit, headIsStore, cdbHit;
  tag_t cdbIdx;
  logic unusedDestBits;

  function automatic tag_t nextPtr(input tag_t p);
    return (p == tag_t'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign notFull     = (count_q != tag_t'(DEPTH));
  assign doIssue     = rdy && (rob.in_dec_op != OP_NOP) && notFull;
  assign doCommit    = rdy && busy_q[head_q] && ready_q[head_q];
  assign headIsStore = op_q[head_q] inside {OP_SB, OP_SH, OP_SW};
  assign cdbIdx      = rob.in_cdb_tag - 1'b1;
  assign cdbHit      = (rob.in_cdb_tag != '0) && busy_q[cdbIdx];

  assign unusedDestBits = ^rob.in_dec_dest[31:5];

  // Freetag comes from registered state only, so a same-cycle retire never frees a slot early.
  assign rob.out_dec_freetag = notFull ? tail_q + 1'b1 : '0;
  assign rob.out_full        = !notFull;

  always_comb begin
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    commitValid_d = 1'b0;
    commitReg_d   = '0;
    commitValue_d = '0;
    commitTag_d   = '0;
    storeTag_d    = '0;
    if (doIssue) tail_d = nextPtr(tail_q);
    if (doCommit) begin
      head_d = nextPtr(head_q);
      if (headIsStore) begin
        storeTag_d = head_q + 1'b1;
      end else begin
        commitValid_d = 1'b1;
        commitReg_d   = dest_q[head_q];
        commitValue_d = value_q[head_q];
        commitTag_d   = head_q + 1'b1;
      end
    end
    case ({doIssue, doCommit})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      commitValid_q <= 1'b0;
      commitReg_q   <= '0;
      commitValue_q <= '0;
      commitTag_q   <= '0;
      storeTag_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        busy_q[i]  <= 1'b0;
        ready_q[i] <= 1'b0;
        op_q[i]    <= '0;
        dest_q[i]  <= '0;
        value_q[i] <= '0;
      end
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      commitValid_q <= commitValid_d;
      commitReg_q   <= commitReg_d;
      commitValue_q <= commitValue_d;
      commitTag_q   <= commitTag_d;
      storeTag_q    <= storeTag_d;
      if (rdy && cdbHit) begin
        value_q[cdbIdx] <= rob.in_cdb_value;
        ready_q[cdbIdx] <= 1'b1;
      end
      if (doIssue) begin
        busy_q[tail_q]  <= 1'b1;
        ready_q[tail_q] <= rob.in_dec_isready;
        op_q[tail_q]    <= rob.in_dec_op;
        dest_q[tail_q]  <= rob.in_dec_dest[4:0];
        value_q[tail_q] <= rob.in_dec_value;
      end
      if (doCommit) begin
        busy_q[head_q]  <= 1'b0;
        ready_q[head_q] <= 1'b0;
      end
    end
  end

  assign rob.out_commit_valid     = rdy && commitValid_q;
  assign rob.out_commit_reg       = rdy ? commitReg_q   : '0;
  assign rob.out_commit_value     = rdy ? commitValue_q : '0;
  assign rob.out_commit_tag       = rdy ? commitTag_q   : '0;
  assign rob.out_store_commit_tag = rdy ? storeTag_q    : '0;

  // Result is {ready, value}; a retiring entry still answers since it is busy until the edge.
  function automatic logic [32:0] fetchEntry(input tag_t tag);
    logic [32:0] r;
    tag_t        idx;
    r   = '0;
    idx = tag - 1'b1;
    if ((tag != '0) && busy_q[idx] && ready_q[idx]) r = {1'b1, value_q[idx]};
`ifdef ROB_CDB_BYPASS_EN
    if ((tag != '0) && (tag == rob.in_cdb_tag) && cdbHit) r = {1'b1, rob.in_cdb_value};
`else
`endif
    return r;
  endfunction

  always_comb begin
    {rob.out_fetch_ready1, rob.out_fetch_value1} = fetchEntry(rob.in_fetch_tag1);
    {rob.out_fetch_ready2, rob.out_fetch_value2} = fetchEntry(rob.in_fetch_tag2);
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: expected retirements are queued at issue and matched on each commit pulse.
// Fetch-bypass expectations follow ROB_CDB_BYPASS_EN.
module tb_reorder_buffer;
  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_LUI  = 6'd1;
  localparam logic [5:0] OP_ADDI = 6'd10;
  localparam logic [5:0] OP_SB   = 6'd20;
  localparam logic [5:0] OP_SH   = 6'd21;
  localparam logic [5:0] OP_SW   = 6'd22;
`ifdef ROB_CDB_BYPASS_EN
  localparam logic BYPASS = 1'b1;
`else
  localparam logic BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  always #5 clk = ~clk;

  reorder_buffer_if #(.TAG_W(4), .OP_W(6)) rob();

  reorder_buffer #(
    .TAG_W(4), .DEPTH(15), .OP_W(6),
    .OP_NOP(OP_NOP), .OP_SB(OP_SB), .OP_SH(OP_SH), .OP_SW(OP_SW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .rob(rob)
  );

  typedef struct {
    logic        isStore;
    logic [4:0]  rd;
    logic [31:0] value;
    logic [3:0]  tag;
  } commitExp_t;

  commitExp_t sb[$];
  commitExp_t exp_e;
  int checkCount = 0;
  int failCount  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input logic isStore, input logic [4:0] rd, input logic [31:0] value, input logic [3:0] tag);
    commitExp_t e;
    e.isStore = isStore;
    e.rd      = rd;
    e.value   = value;
    e.tag     = tag;
    sb.push_back(e);
  endtask

  task automatic applyReset();
    rst                = 1'b1;
    rdy                = 1'b1;
    rob.in_dec_op      = OP_NOP;
    rob.in_dec_dest    = '0;
    rob.in_dec_isready = 1'b0;
    rob.in_dec_value   = '0;
    rob.in_fetch_tag1  = '0;
    rob.in_fetch_tag2  = '0;
    rob.in_cdb_tag     = '0;
    rob.in_cdb_value   = '0;
    step();
    step();
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic [31:0] dest, input logic isReady,
                               input logic [31:0] value, input logic [3:0] expTag);
    checkOutput("freetagBeforeIssue", 32'(rob.out_dec_freetag), 32'(expTag));
    rob.in_dec_op      = op;
    rob.in_dec_dest    = dest;
    rob.in_dec_isready = isReady;
    rob.in_dec_value   = value;
    step();
    rob.in_dec_op      = OP_NOP;
    rob.in_dec_isready = 1'b0;
  endtask

  task automatic cdbBroadcast(input logic [3:0] tag, input logic [31:0] value);
    rob.in_cdb_tag   = tag;
    rob.in_cdb_value = value;
    step();
    rob.in_cdb_tag   = '0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) step();
    checkOutput("scoreboardDrained", 32'(sb.size()), 32'd0);
  endtask

  // Every retirement pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && (rob.out_commit_valid || rob.out_store_commit_tag != '0)) begin
      if (sb.size() == 0) begin
        checkOutput("spuriousCommit", {27'd0, rob.out_commit_valid, rob.out_store_commit_tag}, 32'd0);
      end else begin
        exp_e = sb.pop_front();
        if (exp_e.isStore) begin
          checkOutput("storeTag", 32'(rob.out_store_commit_tag), 32'(exp_e.tag));
          checkOutput("storeNoRegWrite", 32'(rob.out_commit_valid), 32'd0);
        end else begin
          checkOutput("commitValid", 32'(rob.out_commit_valid), 32'd1);
          checkOutput("commitReg", 32'(rob.out_commit_reg), 32'(exp_e.rd));
          checkOutput("commitValue", rob.out_commit_value, exp_e.value);
          checkOutput("commitTag", 32'(rob.out_commit_tag), 32'(exp_e.tag));
          checkOutput("commitNoStore", 32'(rob.out_store_commit_tag), 32'd0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d", checkCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state and single ready-at-issue LUI
    applyReset();
    checkOutput("rstFreetag", 32'(rob.out_dec_freetag), 32'd1);
    checkOutput("rstFull", 32'(rob.out_full), 32'd0);
    checkOutput("rstCommitValid", 32'(rob.out_commit_valid), 32'd0);
    checkOutput("rstStoreTag", 32'(rob.out_store_commit_tag), 32'd0);
    rdy = 1'b0;
    rob.in_dec_op = OP_LUI;
    step();
    rob.in_dec_op = OP_NOP;
    rdy = 1'b1;
    checkOutput("rdyLowNoIssue", 32'(rob.out_dec_freetag), 32'd1);
    pushExp(1'b0, 5'd5, 32'h12345000, 4'd1);
    applyStimulus(OP_LUI, 32'd5, 1'b1, 32'h12345000, 4'd1);
    checkOutput("luiFreetag", 32'(rob.out_dec_freetag), 32'd2);
    checkOutput("luiNotYet", 32'(rob.out_commit_valid), 32'd0);
    step();
    checkOutput("luiPulse", 32'(rob.out_commit_valid), 32'd1);
    checkOutput("luiFreetagAfter", 32'(rob.out_dec_freetag), 32'd2);
    checkOutput("luiEmpty", 32'(rob.out_full), 32'd0);
    step();
    checkOutput("luiPulseEnds", 32'(rob.out_commit_valid), 32'd0);

    // Fill, drop on full, CDB release of the head, then wrap-around reuse
    applyReset();
    pushExp(1'b0, 5'd1, 32'd7, 4'd1);
    for (int i = 0; i < 15; i++) applyStimulus(OP_ADDI, 32'(i + 1), 1'b0, 32'd0, 4'(i + 1));
    checkOutput("fullFlag", 32'(rob.out_full), 32'd1);
    checkOutput("fullFreetag", 32'(rob.out_dec_freetag), 32'd0);
    applyStimulus(OP_ADDI, 32'd9, 1'b1, 32'hDEAD, 4'd0);
    checkOutput("droppedFull", 32'(rob.out_full), 32'd1);
    rob.in_fetch_tag1 = 4'd1;
    #1;
    checkOutput("droppedNoOverwrite", 32'(rob.out_fetch_ready1), 32'd0);
    cdbBroadcast(4'd1, 32'd7);
    checkOutput("cdbFetchReady", 32'(rob.out_fetch_ready1), 32'd1);
    checkOutput("cdbFetchValue", rob.out_fetch_value1, 32'd7);
    checkOutput("noCommitAtCapture", 32'(rob.out_commit_valid), 32'd0);
    step();
    checkOutput("cdbCommitPulse", 32'(rob.out_commit_valid), 32'd1);
    checkOutput("slotFreedFreetag", 32'(rob.out_dec_freetag), 32'd1);
    pushExp(1'b0, 5'd2, 32'h22, 4'd2);
    pushExp(1'b0, 5'd3, 32'h33, 4'd3);
    cdbBroadcast(4'd2, 32'h22);
    cdbBroadcast(4'd3, 32'h33);
    waitDrain();
    applyStimulus(OP_LUI, 32'd10, 1'b1, 32'h1111, 4'd1);
    applyStimulus(OP_LUI, 32'd11, 1'b1, 32'h2222, 4'd2);
    applyStimulus(OP_LUI, 32'd12, 1'b1, 32'h3333, 4'd3);
    checkOutput("refillFull", 32'(rob.out_full), 32'd1);
    rob.in_fetch_tag1 = 4'd1;
    rob.in_fetch_tag2 = 4'd2;
    #1;
    checkOutput("reuseTag1Value", rob.out_fetch_value1, 32'h1111);
    checkOutput("reuseTag2Value", rob.out_fetch_value2, 32'h2222);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("midRstFreetag", 32'(rob.out_dec_freetag), 32'd1);
    checkOutput("midRstFull", 32'(rob.out_full), 32'd0);
    checkOutput("midRstFetch1", 32'(rob.out_fetch_ready1), 32'd0);
    checkOutput("midRstFetch2", 32'(rob.out_fetch_ready2), 32'd0);

    // Out-of-order CDB, in-order retire on consecutive cycles
    applyReset();
    pushExp(1'b0, 5'd3, 32'h55, 4'd1);
    pushExp(1'b0, 5'd4, 32'hAA, 4'd2);
    applyStimulus(OP_ADDI, 32'd3, 1'b0, 32'd0, 4'd1);
    applyStimulus(OP_ADDI, 32'd4, 1'b0, 32'd0, 4'd2);
    cdbBroadcast(4'd2, 32'hAA);
    checkOutput("youngerWaits", 32'(rob.out_commit_valid), 32'd0);
    cdbBroadcast(4'd1, 32'h55);
    checkOutput("orderNoCommitAtCapture", 32'(rob.out_commit_valid), 32'd0);
    step();
    checkOutput("orderFirstTag", 32'(rob.out_commit_tag), 32'd1);
    step();
    checkOutput("orderSecondTag", 32'(rob.out_commit_tag), 32'd2);
    step();
    checkOutput("orderPulseEnds", 32'(rob.out_commit_valid), 32'd0);

    // Store release
    applyReset();
    pushExp(1'b1, 5'd0, 32'd0, 4'd1);
    applyStimulus(OP_SW, 32'h100, 1'b0, 32'd0, 4'd1);
    cdbBroadcast(4'd1, 32'h42);
    checkOutput("storeNotYet", 32'(rob.out_store_commit_tag), 32'd0);
    step();
    checkOutput("storeRelease", 32'(rob.out_store_commit_tag), 32'd1);
    checkOutput("storeValidLow", 32'(rob.out_commit_valid), 32'd0);
    step();
    checkOutput("storeReleaseEnds", 32'(rob.out_store_commit_tag), 32'd0);
    waitDrain();

    // Same-cycle fetch of a broadcasting tag
    applyReset();
    for (int i = 0; i < 3; i++) applyStimulus(OP_ADDI, 32'(i + 6), 1'b0, 32'd0, 4'(i + 1));
    rob.in_fetch_tag1 = 4'd3;
    rob.in_fetch_tag2 = 4'd0;
    rob.in_cdb_tag    = 4'd3;
    rob.in_cdb_value  = 32'h99;
    #1;
    checkOutput("bypassReady", 32'(rob.out_fetch_ready1), 32'(BYPASS));
    checkOutput("bypassValue", rob.out_fetch_value1, BYPASS ? 32'h99 : 32'd0);
    checkOutput("tagZeroNeverReady", 32'(rob.out_fetch_ready2), 32'd0);
    step();
    rob.in_cdb_tag    = 4'd0;
    rob.in_fetch_tag2 = 4'd3;
    #1;
    checkOutput("storedReady1", 32'(rob.out_fetch_ready1), 32'd1);
    checkOutput("storedValue2", rob.out_fetch_value2, 32'h99);
    checkOutput("headBlocksCommit", 32'(rob.out_commit_valid), 32'd0);

    waitDrain();
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end
endmodule
